// File: rtl/rt_ibex_pcs_restore_seq.sv
// PCS restore sequencer: latches a saved-register context and replays it into
// the core register file one slot per granted cycle, stalling the core meanwhile.
module rt_ibex_pcs_restore_seq #(
    parameter int unsigned                    NrSavedRegs = 9,
    parameter int unsigned                    DataWidth   = 32,
    parameter logic [NrSavedRegs-1:0][4:0]    RegMap      = {5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
                                                              5'd7,  5'd6,  5'd5,  5'd1}
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    restore_en_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]   restore_data_i,
    output logic                                    rf_we_o,
    output logic [4:0]                              rf_waddr_o,
    output logic [DataWidth-1:0]                    rf_wdata_o,
    input  logic                                    rf_gnt_i,
    output logic                                    stall_o,
    output logic                                    irq_hold_o,
    output logic                                    done_o,
    output logic                                    err_o
);

    // state  | meaning
    // IDLE   | waiting for a restore pulse
    // WRITE  | replaying slot cnt_q into the register file
    // DONE   | one-cycle completion pulse, core still stalled
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned     CntW     = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
    localparam logic [CntW-1:0] LastSlot = CntW'(NrSavedRegs - 1);

    state_e                                 state_q, state_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic [NrSavedRegs-1:0][DataWidth-1:0]  buf_q, buf_d;
    logic                                   err_q, err_d;

    logic [4:0] slot_addr;
    logic       slot_live;

    assign slot_addr = RegMap[cnt_q];
    assign slot_live = (slot_addr != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (restore_en_i) begin
                    buf_d   = restore_data_i;
                    cnt_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // x0 slots are consumed without a write; live slots wait for grant
                if (!slot_live || rf_gnt_i) begin
                    if (cnt_q == LastSlot) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (restore_en_i && (state_q != StIdle)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = '0;
        stall_o    = (state_q != StIdle);
        irq_hold_o = (state_q != StIdle);
        done_o     = (state_q == StDone);
        err_o      = err_q;
        if ((state_q == StWrite) && slot_live) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = slot_addr;
            rf_wdata_o = buf_q[cnt_q];
        end
    end

endmodule
